// File: rtl/clkdiv_prog.sv
// Runtime-programmable mclk divider: near-50% clkout plus a period-start tick.
// The divisor is captured only at period starts (enable, wrap or sync), so it never glitches mid-period.
module clkdiv_prog #(
  parameter int DIV_W = 20
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             clkout,
  output logic             tick,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] d_q;
  logic             clkout_q;
  logic             tick_q;

  logic [DIV_W-1:0] dn_d;
  logic [DIV_W-1:0] high_d;
  logic [DIV_W-1:0] cnt_inc_d;
  logic             wrap_d;

  // Clamp 0/1 to 2 so every period has at least one high and one low cycle.
  assign dn_d      = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  assign high_d    = d_q - (d_q >> 1);
  assign cnt_inc_d = cnt_q + DIV_W'(1);
  assign wrap_d    = sync || (cnt_q == d_q - DIV_W'(1));

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= DIV_W'(2);
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q  <= RUN;
            d_q      <= dn_d;
            cnt_q    <= '0;
            clkout_q <= 1'b1;
            tick_q   <= 1'b1;
          end else begin
            cnt_q    <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
          end else if (wrap_d) begin
            d_q      <= dn_d;
            cnt_q    <= '0;
            clkout_q <= 1'b1;
            tick_q   <= 1'b1;
          end else begin
            cnt_q    <= cnt_inc_d;
            clkout_q <= (cnt_inc_d < high_d);
            tick_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          clkout_q <= 1'b0;
          tick_q   <= 1'b0;
        end
      endcase
    end
  end

  assign clkout    = clkout_q;
  assign tick      = tick_q;
  assign state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_clkdiv_prog.sv
// Bench for clkdiv_prog: a period-position model checked every cycle, plus directed period/duty checks.
module tb_clkdiv_prog;
  localparam int W = 20;

  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic         en   = 1'b0;
  logic [W-1:0] div  = '0;
  logic         sync = 1'b0;
  logic         clkout;
  logic         tick;
  logic         state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  clkdiv_prog #(.DIV_W(W)) dut (
    .mclk(mclk), .rst(rst), .en(en), .div(div), .sync(sync),
    .clkout(clkout), .tick(tick), .state_dbg(state_dbg)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the output is a function of position within the current period.
  bit m_run = 0;
  int m_d   = 2;
  int m_pos = 0;

  always @(posedge mclk or posedge rst) begin
    if (rst) begin
      m_run = 0;
      m_pos = 0;
      m_d   = 2;
    end else if (!en) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run || sync || m_pos == m_d - 1) begin
      m_run = 1;
      m_d   = (int'(div) < 2) ? 2 : int'(div);
      m_pos = 0;
    end else begin
      m_pos++;
    end
  end

  always @(negedge mclk) begin
    check("model_clkout", int'(clkout), (m_run && m_pos < m_d - m_d / 2) ? 1 : 0);
    check("model_tick", int'(tick), (m_run && m_pos == 0) ? 1 : 0);
    check("model_state", int'(state_dbg), int'(m_run));
  end

  task automatic cyc();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 5000; i++) begin
      cyc();
      if (tick) return;
    end
    check("wait_tick_timeout", 0, 1);
  endtask

  // Entered on a tick cycle; returns length and high count of the current period.
  task automatic measure(input int chg_at, input logic [W-1:0] new_div,
                         output int len, output int highs);
    len   = 1;
    highs = int'(clkout);
    for (int i = 0; i < 5000; i++) begin
      if (len - 1 == chg_at) div = new_div;
      cyc();
      if (tick) return;
      len++;
      highs += int'(clkout);
    end
    check("measure_timeout", 0, 1);
  endtask

  int len, highs, ticks;
  logic [9:0] pat, tpat;

  initial begin
    #2;
    check("reset_clkout", int'(clkout), 0);
    check("reset_tick", int'(tick), 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    check("idle_clkout", int'(clkout), 0);

    // div=1000: first tick on the edge en is sampled, 500H/500L
    en  = 1'b1;
    div = W'(1000);
    cyc();
    check("first_tick", int'(tick), 1);
    check("first_clkout", int'(clkout), 1);
    measure(-1, '0, len, highs);
    check("p1000_len", len, 1000);
    check("p1000_high", highs, 500);
    ticks = 0;
    for (int i = 0; i < 1999; i++) begin
      if (i == 1000) div = W'(5);
      cyc();
      ticks += int'(tick);
    end
    check("p1000_ticks", ticks, 1);

    // div=5 -> 1,1,1,0,0
    wait_tick();
    if (len == 1000) wait_tick();
    for (int i = 9; i >= 0; i--) begin
      pat[i]  = clkout;
      tpat[i] = tick;
      if (i > 0) cyc();
    end
    check("p5_pattern", int'(pat), 10'b1110011100);
    check("p5_ticks", int'(tpat), 10'b1000010000);

    // div=0 and div=1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      div = W'(d);
      wait_tick();
      wait_tick();
      for (int i = 3; i >= 0; i--) begin
        pat[i]  = clkout;
        tpat[i] = tick;
        if (i > 0) cyc();
      end
      check(d == 0 ? "p0_pattern" : "p1_pattern", int'(pat[3:0]), 4'b1010);
      check(d == 0 ? "p0_ticks" : "p1_ticks", int'(tpat[3:0]), 4'b1010);
    end

    // 10 -> 4 changed at cnt=3
    div = W'(10);
    wait_tick();
    wait_tick();
    measure(3, W'(4), len, highs);
    check("chg_old_len", len, 10);
    check("chg_old_high", highs, 5);
    measure(-1, '0, len, highs);
    check("chg_new_len", len, 4);
    check("chg_new_high", highs, 2);

    // sync at cnt=6 with div=10
    div = W'(10);
    wait_tick();
    wait_tick();
    for (int i = 0; i < 6; i++) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    check("sync_tick", int'(tick), 1);
    check("sync_clkout", int'(clkout), 1);
    measure(-1, '0, len, highs);
    check("sync_len", len, 10);

    // en dropped at cnt=2, re-raised 3 cycles later
    wait_tick();
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    check("en_off_clkout", int'(clkout), 0);
    check("en_off_tick", int'(tick), 0);
    cyc();
    cyc();
    en = 1'b1;
    cyc();
    check("en_on_tick", int'(tick), 1);
    measure(-1, '0, len, highs);
    check("en_on_len", len, 10);
    check("en_on_high", highs, 5);

    // asynchronous reset mid-period
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("rst_async_clkout", int'(clkout), 0);
    check("rst_async_tick", int'(tick), 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("rst_restart_tick", int'(tick), 1);
    measure(-1, '0, len, highs);
    check("rst_restart_len", len, 10);

    // randomized en/sync/div traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      sync = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) div = W'($urandom_range(0, 12));
      cyc();
    end
    en   = 1'b0;
    sync = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
